// File: rtl/simt_pkg.sv
// rtl/simt_pkg.sv - shared types and constants for the SIMT warp issue stage
package simt_pkg;

    localparam int LANE_W = 4;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLT = 4'd5,
        SLL = 4'd6,
        SRL = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } issue_state_e;

    localparam logic [3:0] OP_MAX = 4'(SRL);

endpackage

// File: rtl/simt_warp_issue_if.sv
// rtl/simt_warp_issue_if.sv - instruction, ALU-group and result bundle of the warp issue stage
interface simt_warp_issue_if
    import simt_pkg::*;
#(
    parameter int LANES = 8,
    parameter int GROUP = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [3:0]                in_opcode;
    logic [LANES*LANE_W-1:0]   in_a;
    logic [LANES*LANE_W-1:0]   in_b;
    logic [LANES-1:0]          in_mask;
    logic [3:0]                alu_opcode;
    logic [GROUP*LANE_W-1:0]   alu_a;
    logic [GROUP*LANE_W-1:0]   alu_b;
    logic [GROUP*LANE_W-1:0]   alu_result;
    logic [GROUP-1:0]          alu_zero;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   out_result;
    logic [LANES-1:0]          out_zero;
    logic                      out_illegal;

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_mask,
        input  in_ready,
        input  alu_opcode, alu_a, alu_b,
        output alu_result, alu_zero,
        input  out_valid, out_result, out_zero, out_illegal,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_mask,
        output in_ready,
        output alu_opcode, alu_a, alu_b,
        input  alu_result, alu_zero,
        output out_valid, out_result, out_zero, out_illegal,
        input  out_ready
    );

endinterface

// File: rtl/simt_group_finder.sv
// rtl/simt_group_finder.sv - lowest lane group with any active mask bit above a given group
module simt_group_finder #(
    parameter int LANES = 8,
    parameter int GROUP = 2,
    parameter int P     = LANES / GROUP,
    parameter int IW    = (P > 1) ? $clog2(P) : 1
) (
    input  logic [LANES-1:0] mask,
    input  logic [IW-1:0]    cur,
    input  logic             first,
    output logic [IW-1:0]    next,
    output logic             found
);

    // Descending scan so the lowest qualifying group is the last one written.
    always_comb begin
        found = 1'b0;
        next  = '0;
        for (int g = P - 1; g >= 0; g--) begin
            if ((GROUP'(mask >> (g * GROUP)) != '0) && (first || (g > int'(cur)))) begin
                found = 1'b1;
                next  = IW'(g);
            end
        end
    end

endmodule

// File: rtl/simt_warp_issue.sv
// rtl/simt_warp_issue.sv - issues warp lanes to an ALU group pass by pass and collects results
module simt_warp_issue
    import simt_pkg::*;
#(
    parameter int LANES = 8,
    parameter int GROUP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    simt_warp_issue_if.slave bus
);

    localparam int P  = LANES / GROUP;
    localparam int IW = (P > 1) ? $clog2(P) : 1;
    localparam int DW = LANES * LANE_W;
    localparam int GW = GROUP * LANE_W;

    issue_state_e      state;
    logic [3:0]        opc_q;
    logic [DW-1:0]     a_q;
    logic [DW-1:0]     b_q;
    logic [LANES-1:0]  mask_q;
    logic [IW-1:0]     pass;
    logic [DW-1:0]     res_q;
    logic [LANES-1:0]  zero_q;
    logic              illegal_q;
    logic              out_valid_q;
    logic [GW-1:0]     alu_a_q;
    logic [GW-1:0]     alu_b_q;

    logic [IW-1:0]     first_g;
    logic              first_found;
    logic [IW-1:0]     next_g;
    logic              next_found;

    simt_group_finder #(.LANES(LANES), .GROUP(GROUP)) u_first (
        .mask  (bus.in_mask),
        .cur   ('0),
        .first (1'b1),
        .next  (first_g),
        .found (first_found)
    );

    simt_group_finder #(.LANES(LANES), .GROUP(GROUP)) u_next (
        .mask  (mask_q),
        .cur   (pass),
        .first (1'b0),
        .next  (next_g),
        .found (next_found)
    );

    // Full-width views of the current pass so the buffer update is a masked merge.
    logic [LANES-1:0]  lane_en;
    logic [DW-1:0]     nib_en;
    logic [DW-1:0]     ext_res;
    logic [LANES-1:0]  ext_zero;

    always_comb begin
        lane_en  = mask_q & (LANES'({GROUP{1'b1}}) << (int'(pass) * GROUP));
        ext_res  = DW'(bus.alu_result) << (int'(pass) * GW);
        ext_zero = LANES'(bus.alu_zero) << (int'(pass) * GROUP);
        nib_en   = '0;
        for (int i = 0; i < LANES; i++) begin
            nib_en[i*LANE_W +: LANE_W] = {LANE_W{lane_en[i]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mask_q      <= '0;
            pass        <= '0;
            res_q       <= '0;
            zero_q      <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opc_q     <= bus.in_opcode;
                        a_q       <= bus.in_a;
                        b_q       <= bus.in_b;
                        mask_q    <= bus.in_mask;
                        res_q     <= '0;
                        zero_q    <= '0;
                        illegal_q <= (bus.in_opcode > OP_MAX);
                        if (first_found && (bus.in_opcode <= OP_MAX)) begin
                            state   <= ISSUE;
                            pass    <= first_g;
                            alu_a_q <= GW'(bus.in_a >> (int'(first_g) * GW));
                            alu_b_q <= GW'(bus.in_b >> (int'(first_g) * GW));
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    res_q  <= (res_q & ~nib_en) | (ext_res & nib_en);
                    zero_q <= (zero_q & ~lane_en) | (ext_zero & lane_en);
                    if (next_found) begin
                        pass    <= next_g;
                        alu_a_q <= GW'(a_q >> (int'(next_g) * GW));
                        alu_b_q <= GW'(b_q >> (int'(next_g) * GW));
                    end else begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.alu_opcode  = opc_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = res_q;
    assign bus.out_zero    = zero_q;
    assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_simt_warp_issue.sv
// tb/tb_simt_warp_issue.sv - randomized self-checking bench for simt_warp_issue
module tb_simt_warp_issue;

    localparam int LANES = 8;
    localparam int GROUP = 2;
    localparam int P     = LANES / GROUP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    simt_warp_issue_if #(.LANES(LANES), .GROUP(GROUP)) bus ();

    simt_warp_issue #(.LANES(LANES), .GROUP(GROUP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (a < b) ? 4'd1 : 4'd0;
            4'd6:    return a << b[1:0];
            4'd7:    return a >> b[1:0];
            default: return 4'd0;
        endcase
    endfunction

    // Stand-in for the external ALU lanes.
    logic [GROUP*4-1:0] alu_r;
    logic [GROUP-1:0]   alu_z;
    always_comb begin
        alu_r = '0;
        alu_z = '0;
        for (int j = 0; j < GROUP; j++) begin
            alu_r[j*4 +: 4] = alu_f(bus.alu_opcode, bus.alu_a[j*4 +: 4], bus.alu_b[j*4 +: 4]);
            alu_z[j]        = (alu_r[j*4 +: 4] == 4'd0);
        end
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_zero   = alu_z;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge with the stage idle; returns at a negedge with the stage idle again.
    task automatic run_warp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] m, input int hold);
        logic [31:0] er;
        logic [7:0]  ez;
        int          grp[$];
        int          ng;
        int          cyc;
        int          g;
        bit          legal;
        legal = (op <= 4'd7);
        er = '0;
        ez = '0;
        grp = {};
        for (int i = 0; i < LANES; i++) begin
            if (legal && m[i]) begin
                er[i*4 +: 4] = alu_f(op, a[i*4 +: 4], b[i*4 +: 4]);
                ez[i]        = (er[i*4 +: 4] == 4'd0);
            end
        end
        for (int k = 0; k < P; k++) begin
            if (legal && (m[k*GROUP +: GROUP] != '0)) grp.push_back(k);
        end
        ng = grp.size();

        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_mask   = m;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_opcode = 4'($urandom);
        bus.in_a      = $urandom;
        bus.in_b      = $urandom;
        bus.in_mask   = 8'($urandom);

        cyc = 1;
        while (!bus.out_valid && cyc <= P + 2) begin
            if (grp.size() > 0) begin
                g = grp.pop_front();
                check("issue_alu_a", bus.alu_a, a[g*8 +: 8]);
                check("issue_alu_b", bus.alu_b, b[g*8 +: 8]);
                check("issue_opcode", bus.alu_opcode, op);
            end else begin
                check("extra_issue_cycle", cyc, ng);
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, ng + 1);
        check("out_result", bus.out_result, er);
        check("out_zero", bus.out_zero, ez);
        check("out_illegal", bus.out_illegal, !legal);
        check("alu_a_idle", {bus.alu_a, bus.alu_b}, 0);
        check("in_ready_done", bus.in_ready, 0);

        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", {bus.out_illegal, bus.out_zero, bus.out_result}, {!legal, ez, er});
            check("hold_in_ready", bus.in_ready, 0);
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_valid", bus.out_valid, 0);
        check("post_hs_ready", bus.in_ready, 1);
        check("post_hs_illegal", bus.out_illegal, 0);
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] m;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b0;

        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_outputs", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_result}, 0);
        check("rst_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_warp(4'd0, 32'h3333_3333, 32'h5555_5555, 8'hFF, 0);
        run_warp(4'd1, 32'h7777_7777, 32'h7777_7777, 8'h0F, 0);
        run_warp(4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 8'h81, 0);
        run_warp(4'd0, 32'h1234_5678, 32'h1111_1111, 8'h00, 0);
        run_warp(4'hA, 32'h1234_5678, 32'h1111_1111, 8'hFF, 0);
        run_warp(4'd3, 32'h0F0F_1234, 32'h8421_0000, 8'h3C, 10);

        // Reset during the second ISSUE cycle abandons the warp.
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'd0;
        bus.in_a      = 32'h2222_2222;
        bus.in_b      = 32'h1111_1111;
        bus.in_mask   = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_result}, 0);
        check("midrst_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_no_valid", bus.out_valid, 0);
        run_warp(4'd5, 32'h0123_4567, 32'h4444_4444, 8'hA5, 1);

        for (int t = 0; t < 40; t++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            m  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_warp(op, $urandom, $urandom, m, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
